mon_mult_radix2: RTL and testbench



---
 rtl/mon_mult_radix2_pkg.sv | 14 +
 rtl/mon_mult_radix2_cond_sub.sv | 13 +
 rtl/mon_mult_radix2.sv | 107 ++++++++++
 tb/tb_mon_mult_radix2.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mon_mult_radix2_pkg.sv
// Shared widths and state encodings for the Montgomery product engine and
// the modular-exponentiation controller that drives it.
package mon_mult_radix2_pkg;

    localparam int BITLEN     = 1024;
    localparam int log_BITLEN = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOOP = 2'd1,
        FIX  = 2'd2
    } state_t;

endpackage

// File: rtl/mon_mult_radix2_cond_sub.sv
// Combinational compare-and-subtract: y = (x >= m) ? x - m : x.
// Also reused by the out-of-Montgomery-domain conversion step.
module mon_mult_radix2_cond_sub #(
    parameter int W = 1026
) (
    input  logic [W-1:0] x,
    input  logic [W-1:0] m,
    output logic [W-1:0] y
);

    assign y = (x >= m) ? x - m : x;

endmodule

// File: rtl/mon_mult_radix2.sv
// Bit-serial radix-2 Montgomery multiplier: P = A*B*2^-N mod M, one
// multiplier bit per clock followed by a single conditional subtraction.
module mon_mult_radix2
    import mon_mult_radix2_pkg::*;
#(
    parameter int N     = BITLEN,
    parameter int LOG_N = log_BITLEN
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic [N-1:0] M,
    output logic [N-1:0] P,
    output logic         stop,
    output logic         busy
);

    localparam logic [LOG_N-1:0] LAST = LOG_N'(N - 1);

    state_t         state, state_n;
    logic [N-1:0]   a_sh, a_sh_n, b_r, b_r_n, m_r, m_r_n, p_n;
    logic [N+1:0]   acc, acc_n;
    logic [LOG_N-1:0] cnt, cnt_n;
    logic           stop_n, busy_n;

    logic [N+1:0]   t_add, t_sum, fix_val;
    logic           unused_bits;

    // acc < 2M and each addend < M, so the sum stays below 4M < 2^(N+2).
    assign t_add = acc + (N+2)'(a_sh[0] ? b_r : '0);
    assign t_sum = t_add[0] ? t_add + (N+2)'(m_r) : t_add;

    mon_mult_radix2_cond_sub #(.W(N + 2)) u_cond_sub (
        .x (acc),
        .m ((N+2)'(m_r)),
        .y (fix_val)
    );

    // t_sum[0] is always zero after the conditional add; the top bits of the
    // corrected result are zero whenever the operands meet the preconditions.
    assign unused_bits = ^{fix_val[N+1:N], t_sum[0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_r   <= '0;
            m_r   <= '0;
            acc   <= '0;
            cnt   <= '0;
            P     <= '0;
            stop  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            state <= state_n;
            a_sh  <= a_sh_n;
            b_r   <= b_r_n;
            m_r   <= m_r_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            P     <= p_n;
            stop  <= stop_n;
            busy  <= busy_n;
        end
    end

    always_comb begin
        state_n = state;
        a_sh_n  = a_sh;
        b_r_n   = b_r;
        m_r_n   = m_r;
        acc_n   = acc;
        cnt_n   = cnt;
        p_n     = P;
        stop_n  = 1'b0;
        busy_n  = busy;
        case (state)
            IDLE: begin
                if (start) begin
                    a_sh_n  = A;
                    b_r_n   = B;
                    m_r_n   = M;
                    acc_n   = '0;
                    cnt_n   = '0;
                    busy_n  = 1'b1;
                    state_n = LOOP;
                end
            end
            LOOP: begin
                acc_n  = {1'b0, t_sum[N+1:1]};
                a_sh_n = a_sh >> 1;
                cnt_n  = cnt + 1'b1;
                if (cnt == LAST) state_n = FIX;
            end
            FIX: begin
                p_n     = fix_val[N-1:0];
                stop_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mon_mult_radix2.sv
// Scoreboard bench for mon_mult_radix2 at N=8 (R=256).
module tb_mon_mult_radix2;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [N-1:0] A = '0, B = '0, M = '0;
    logic [N-1:0] P;
    logic         stop, busy;

    typedef struct {
        logic [N-1:0] p;
        int           cyc;
        string        name;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   nstops = 0;
    int   last_k = 0;

    mon_mult_radix2 #(.N(N), .LOG_N(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .M     (M),
        .P     (P),
        .stop  (stop),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Monitor: every stop pulse must match the oldest expectation, value and cycle.
    always @(negedge clk) begin
        if (!rst && stop) begin
            nstops++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_stop: cycle=%0d P=%0d, no result was pending", cyc, P);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (P !== e.p || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL %s: got P=%0d at cycle %0d, expected P=%0d at cycle %0d",
                             e.name, P, cyc, e.p, e.cyc);
                end
            end
        end
    end

    function automatic logic [N-1:0] model(input int a, input int b, input int m);
        int rinv;
        rinv = 0;
        for (int x = 0; x < m; x++)
            if (((x * 256) % m) == (1 % m)) begin
                rinv = x;
                break;
            end
        return N'(((a * b) % m) * rinv % m);
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Issue one product while the DUT is idle; returns at the negedge after acceptance.
    task automatic issue(input int a, input int b, input int m, input int p,
                         input bit push, input string name);
        @(negedge clk);
        A = N'(a); B = N'(b); M = N'(m); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        last_k = cyc;
        if (push) q.push_back('{p: N'(p), cyc: last_k + N + 1, name: name});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results still pending", q.size());
            q.delete();
        end
        @(negedge clk);
    endtask

    typedef struct { int a; int b; int m; int p; string name; } vec_t;
    vec_t vecs[$];

    initial begin
        int n0;
        // Reset held with start asserted: outputs stay at reset values.
        A = 8'd5; B = 8'd7; M = 8'd13; start = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("reset_hold", {P, stop, busy}, 0);
        end
        rst = 1'b0;
        @(negedge clk);
        start = 1'b0;
        last_k = cyc;
        q.push_back('{p: 8'd1, cyc: last_k + N + 1, name: "first_after_reset"});
        check("busy_after_release", busy, 1);
        wait_idle();

        // Basic product with busy window.
        issue(5, 7, 13, 1, 1'b1, "basic_5x7");
        for (int off = 0; off <= 9; off++) begin
            check($sformatf("busy_off%0d", off), busy, off <= 8);
            if (off < 9) @(negedge clk);
        end
        wait_idle();

        vecs.push_back('{12, 12, 13, 3, "sub_12x12"});
        vecs.push_back('{0, 9, 13, 0, "zero_a"});
        vecs.push_back('{1, 1, 13, 3, "one_one"});
        vecs.push_back('{200, 100, 255, 110, "m255"});
        vecs.push_back('{2, 3, 251, 202, "m251"});
        vecs.push_back('{2, 2, 3, 1, "m3"});
        vecs.push_back('{14, 14, 15, 1, "m15"});
        foreach (vecs[i]) begin
            issue(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].p, 1'b1, vecs[i].name);
            wait_idle();
        end

        // Operand changes and start while busy are ignored.
        issue(5, 7, 13, 1, 1'b1, "midloop_change");
        repeat (3) @(negedge clk);
        A = 8'hff; B = 8'haa; M = 8'h22; start = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Back-to-back: start held through the stop cycle is taken there.
        issue(5, 7, 13, 1, 1'b1, "b2b_first");
        A = 8'd12; B = 8'd12; M = 8'd13; start = 1'b1;
        q.push_back('{p: 8'd3, cyc: last_k + 2 * (N + 2) - 1, name: "b2b_second"});
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (stop) break;
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();

        // Reset mid-LOOP: no stop for the aborted product.
        issue(5, 7, 13, 0, 1'b0, "aborted");
        n0 = nstops;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset_outputs", {P, stop, busy}, 0);
        repeat (12) @(negedge clk);
        rst = 1'b0;
        check("no_stop_after_abort", nstops - n0, 0);
        issue(12, 12, 13, 3, 1'b1, "after_abort_12x12");
        wait_idle();

        // Random operands against the brute-force model.
        for (int i = 0; i < 20; i++) begin
            int m, a, b;
            m = 2 * $urandom_range(1, 127) + 1;
            a = $urandom_range(0, m - 1);
            b = $urandom_range(0, m - 1);
            issue(a, b, m, model(a, b, m), 1'b1, $sformatf("rand_%0d_%0dx%0d_m%0d", i, a, b, m));
            wait_idle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
